serial_add_unit: RTL and testbench

//  Multi-cycle, bit-serial add/subtract stage built around a single full-adder

---
 rtl/serial_add_unit.sv | 158 +++++++++++++++
 tb/tb_serial_add_unit.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_unit.sv
// Bit-serial add/subtract unit: one full-adder slice plus a carry flop,
// sequenced LSB-first over WIDTH cycles behind a start/busy/done handshake.
module serial_add_unit #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    function automatic logic maj3(input logic x, input logic y, input logic z);
        return (x & y) | (x & z) | (y & z);
    endfunction

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic             c_q, c_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             carry_out_q, carry_out_d;
    logic             overflow_q, overflow_d;
    logic             zero_q, zero_d;

    logic             sum_bit_s;
    logic             carry_nxt_s;
    logic [WIDTH-1:0] result_nxt_s;

    // Next-state, datapath and flag computation for the serial sequencer.
    always_comb begin
        state_d      = state_q;
        a_sh_d       = a_sh_q;
        b_sh_d       = b_sh_q;
        c_d          = c_q;
        cnt_d        = cnt_q;
        a_msb_d      = a_msb_q;
        b_msb_d      = b_msb_q;
        busy_d       = busy_q;
        done_d       = done_q;
        result_d     = result_q;
        carry_out_d  = carry_out_q;
        overflow_d   = overflow_q;
        zero_d       = zero_q;

        sum_bit_s    = a_sh_q[0] ^ b_sh_q[0] ^ c_q;
        carry_nxt_s  = maj3(a_sh_q[0], b_sh_q[0], c_q);
        result_nxt_s = {sum_bit_s, result_q[WIDTH-1:1]};

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    // Subtraction is a + ~b + 1: invert b and seed the carry with 1.
                    state_d     = S_RUN;
                    a_sh_d      = a;
                    b_sh_d      = sub ? ~b : b;
                    c_d         = sub;
                    cnt_d       = '0;
                    a_msb_d     = a[WIDTH-1];
                    b_msb_d     = sub ? ~b[WIDTH-1] : b[WIDTH-1];
                    busy_d      = 1'b1;
                    done_d      = 1'b0;
                    result_d    = '0;
                    carry_out_d = 1'b0;
                    overflow_d  = 1'b0;
                    zero_d      = 1'b0;
                end else begin
                    state_d = S_IDLE;
                    done_d  = 1'b0;
                end
            end
            S_RUN: begin
                a_sh_d   = {1'b0, a_sh_q[WIDTH-1:1]};
                b_sh_d   = {1'b0, b_sh_q[WIDTH-1:1]};
                c_d      = carry_nxt_s;
                result_d = result_nxt_s;
                if (cnt_q == CNT_LAST) begin
                    state_d     = S_DONE;
                    cnt_d       = '0;
                    busy_d      = 1'b0;
                    done_d      = 1'b1;
                    carry_out_d = carry_nxt_s;
                    overflow_d  = (a_msb_q == b_msb_q) && (sum_bit_s != a_msb_q);
                    zero_d      = ~|result_nxt_s;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            a_sh_q      <= '0;
            b_sh_q      <= '0;
            c_q         <= 1'b0;
            cnt_q       <= '0;
            a_msb_q     <= 1'b0;
            b_msb_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            result_q    <= '0;
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
            zero_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_sh_q      <= a_sh_d;
            b_sh_q      <= b_sh_d;
            c_q         <= c_d;
            cnt_q       <= cnt_d;
            a_msb_q     <= a_msb_d;
            b_msb_q     <= b_msb_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            result_q    <= result_d;
            carry_out_q <= carry_out_d;
            overflow_q  <= overflow_d;
            zero_q      <= zero_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign result    = result_q;
    assign carry_out = carry_out_q;
    assign overflow  = overflow_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_serial_add_unit.sv
// Scoreboard bench for serial_add_unit: expected results from plain integer
// arithmetic are queued at issue time and popped by a monitor on each done pulse.
module tb_serial_add_unit;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         carry_out;
    logic         overflow;
    logic         zero;

    serial_add_unit #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .sub       (sub),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .carry_out (carry_out),
        .overflow  (overflow),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] res;
        logic         co;
        logic         ov;
        logic         z;
        int           cyc;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Reference: plain modular and signed integer arithmetic.
    function automatic exp_t model(input logic [W-1:0] aa, input logic [W-1:0] bb, input logic ss);
        exp_t e;
        int ua, ub, sa, sb, r, sr;
        ua = int'(aa);
        ub = int'(bb);
        sa = $signed(aa);
        sb = $signed(bb);
        if (!ss) begin
            r    = ua + ub;
            sr   = sa + sb;
            e.co = (r >= (1 << W));
        end else begin
            r    = ua - ub;
            sr   = sa - sb;
            e.co = (ua >= ub);
        end
        e.res = r[W-1:0];
        e.ov  = (sr > ((1 << (W - 1)) - 1)) || (sr < -(1 << (W - 1)));
        e.z   = (e.res == '0);
        e.cyc = 0;
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [W-1:0] aa, input logic [W-1:0] bb, input logic ss);
        exp_t e;
        a     = aa;
        b     = bb;
        sub   = ss;
        start = 1'b1;
        e     = model(aa, bb, ss);
        e.cyc = cyc + 1 + W;
        sbq.push_back(e);
        tick();
        start = 1'b0;
        a     = W'($urandom);
        b     = W'($urandom);
        sub   = 1'($urandom);
        chk("busy_after_start", {31'd0, busy}, 32'd1);
        chk("done_after_start", {31'd0, done}, 32'd0);
    endtask

    task automatic wait_done();
        for (int i = 0; i < W + 4; i++) begin
            if (done) break;
            tick();
        end
        chk("done_timeout", {31'd0, done}, 32'd1);
    endtask

    task automatic check_cleared(input string tag);
        chk({tag, "_busy"},   {31'd0, busy},      32'd0);
        chk({tag, "_done"},   {31'd0, done},      32'd0);
        chk({tag, "_result"}, {24'd0, result},    32'd0);
        chk({tag, "_carry"},  {31'd0, carry_out}, 32'd0);
        chk({tag, "_ovf"},    {31'd0, overflow},  32'd0);
        chk({tag, "_zero"},   {31'd0, zero},      32'd0);
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (sbq.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: result %0h with no pending op (t=%0t)", result, $time);
            end else begin
                mon_e = sbq.pop_front();
                chk("result",    {24'd0, result},    {24'd0, mon_e.res});
                chk("carry_out", {31'd0, carry_out}, {31'd0, mon_e.co});
                chk("overflow",  {31'd0, overflow},  {31'd0, mon_e.ov});
                chk("zero",      {31'd0, zero},      {31'd0, mon_e.z});
                chk("latency",   cyc,                mon_e.cyc);
                chk("busy_at_done", {31'd0, busy},   32'd0);
            end
        end
    end

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        sub   = 1'b0;
        a     = '0;
        b     = '0;
        repeat (2) @(posedge clk);
        #1;
        check_cleared("reset");
        rst = 1'b0;
        tick();

        // Directed vectors.
        issue(8'h3C, 8'h0F, 1'b0); wait_done(); tick();
        issue(8'hFF, 8'h01, 1'b0); wait_done(); tick();
        issue(8'h05, 8'h07, 1'b1); wait_done(); tick();
        issue(8'h7F, 8'h01, 1'b0); wait_done(); tick();
        issue(8'h80, 8'h01, 1'b1); wait_done(); tick();

        // Start during RUN is ignored; start in the DONE cycle is accepted.
        issue(8'h21, 8'h11, 1'b0);
        repeat (2) tick();
        a     = 8'hAA;
        b     = 8'h55;
        sub   = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done();
        issue(8'h10, 8'h20, 1'b1);
        wait_done();
        tick();

        // Reset in the middle of RUN.
        issue(8'h12, 8'h34, 1'b0);
        repeat (3) tick();
        rst = 1'b1;
        #1;
        check_cleared("midrun_rst");
        sbq.delete();
        tick();
        rst = 1'b0;
        repeat (W + 3) tick();
        issue(8'h40, 8'h40, 1'b0); wait_done(); tick();

        // Random operations, some back-to-back, some with idle gaps.
        for (int n = 0; n < 40; n++) begin
            issue(W'($urandom), W'($urandom), 1'($urandom));
            wait_done();
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(1, 3)) tick();
            end
        end
        repeat (W + 3) tick();
        chk("scoreboard_empty", sbq.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
